// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and defaults for the data cache controller.
//   state_e      controller FSM states
//   DEF_*        default SETS / BASE_ADDR / CNT_W
//   idx_w/tag_w  index and tag widths derived from the number of sets
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR      = 2'd2
  } state_e;

  localparam int unsigned DEF_SETS      = 16;
  localparam int unsigned DEF_BASE_ADDR = 1024;
  localparam int unsigned DEF_CNT_W     = 16;

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  // Byte offset is 2 bits, so the tag is whatever remains of the 32-bit address.
  function automatic int tag_w(input int sets);
    return 30 - $clog2(sets);
  endfunction

endpackage

// File: rtl/dcache_array.sv
// dcache_array: valid/tag/data storage for a direct-mapped, one-word-per-line cache.
//   clk, rst            clock, async active-high reset (clears valid bits only)
//   idx                 line index, shared by read and write
//   fill_en/tag/data    allocate the line on a read-miss fill
//   upd_en/data         overwrite data of an already-valid line (write hit)
//   rd_valid/tag/data   combinational read of the indexed line
module dcache_array
  import dcache_pkg::*;
#(
  parameter int SETS  = DEF_SETS,
  parameter int IDX_W = idx_w(DEF_SETS),
  parameter int TAG_W = tag_w(DEF_SETS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] idx,
  input  logic             fill_en,
  input  logic [TAG_W-1:0] fill_tag,
  input  logic [31:0]      fill_data,
  input  logic             upd_en,
  input  logic [31:0]      upd_data,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_data
);

  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [31:0]      data_q [SETS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (fill_en) begin
      valid_q[idx] <= 1'b1;
    end
  end

  // Tag and data contents are meaningless until valid is set, so no reset here.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[idx]  <= fill_tag;
      data_q[idx] <= fill_data;
    end else if (upd_en) begin
      data_q[idx] <= upd_data;
    end
  end

  assign rd_valid = valid_q[idx];
  assign rd_tag   = tag_q[idx];
  assign rd_data  = data_q[idx];

endmodule

// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped, write-through, no-write-allocate data cache
// between the MEM stage and the data memory.
//   mem_read/mem_write/address/write_data   upstream request (held until ready)
//   read_data/ready                         upstream response
//   dm_*                                    downstream data memory handshake
//   hit_count/miss_count                    saturating read hit/miss statistics
// Read hits complete in the request cycle; misses and writes take at least two.
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int SETS      = DEF_SETS,
  parameter int BASE_ADDR = DEF_BASE_ADDR,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [31:0]      address,
  input  logic [31:0]      write_data,
  output logic [31:0]      read_data,
  output logic             ready,
  output logic             dm_read,
  output logic             dm_write,
  output logic [31:0]      dm_address,
  output logic [31:0]      dm_write_data,
  input  logic [31:0]      dm_read_data,
  input  logic             dm_ready,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int IDX_W = idx_w(SETS);
  localparam int TAG_W = tag_w(SETS);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] hit_cnt_q, miss_cnt_q;
  logic             hit_inc, miss_inc;
  logic             fill_en, upd_en;
  logic             cacheable, hit;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic [31:0]      rd_data;

  assign idx       = address[IDX_W+1:2];
  assign tag       = address[31:IDX_W+2];
  assign cacheable = (address >= 32'(BASE_ADDR));
  // Uncached addresses are never filled, but gate anyway so they can never hit.
  assign hit       = cacheable && rd_valid && (rd_tag == tag);

  dcache_array #(
    .SETS (SETS),
    .IDX_W(IDX_W),
    .TAG_W(TAG_W)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .idx      (idx),
    .fill_en  (fill_en),
    .fill_tag (tag),
    .fill_data(dm_read_data),
    .upd_en   (upd_en),
    .upd_data (write_data),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ready     = 1'b0;
    read_data = '0;
    dm_read   = 1'b0;
    dm_write  = 1'b0;
    fill_en   = 1'b0;
    upd_en    = 1'b0;
    hit_inc   = 1'b0;
    miss_inc  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A simultaneous read+write is handled as a write.
        if (mem_write) begin
          state_d = WR;
        end else if (mem_read) begin
          if (hit) begin
            ready     = 1'b1;
            read_data = rd_data;
            hit_inc   = 1'b1;
          end else begin
            state_d  = RD_MISS;
            miss_inc = cacheable;
          end
        end else begin
          ready = 1'b1;
        end
      end
      RD_MISS: begin
        dm_read = 1'b1;
        if (dm_ready) begin
          ready     = 1'b1;
          read_data = mem_read ? dm_read_data : '0;
          fill_en   = cacheable;
          state_d   = IDLE;
        end
      end
      WR: begin
        dm_write = 1'b1;
        if (dm_ready) begin
          ready   = 1'b1;
          upd_en  = hit;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit_inc && (hit_cnt_q != '1)) begin
        hit_cnt_q <= hit_cnt_q + 1'b1;
      end
      if (miss_inc && (miss_cnt_q != '1)) begin
        miss_cnt_q <= miss_cnt_q + 1'b1;
      end
    end
  end

  assign hit_count     = hit_cnt_q;
  assign miss_count    = miss_cnt_q;
  assign dm_address    = address;
  assign dm_write_data = write_data;

endmodule

// File: tb/tb_dcache_controller.sv
module tb_dcache_controller;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             mem_read, mem_write;
  logic [31:0]      address, write_data;
  logic [31:0]      read_data;
  logic             ready;
  logic             dm_read, dm_write;
  logic [31:0]      dm_address, dm_write_data;
  logic [31:0]      dm_read_data;
  logic             dm_ready;
  logic [CNT_W-1:0] hit_count, miss_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dcache_controller #(
    .SETS     (16),
    .BASE_ADDR(1024),
    .CNT_W    (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .address      (address),
    .write_data   (write_data),
    .read_data    (read_data),
    .ready        (ready),
    .dm_read      (dm_read),
    .dm_write     (dm_write),
    .dm_address   (dm_address),
    .dm_write_data(dm_write_data),
    .dm_read_data (dm_read_data),
    .dm_ready     (dm_ready),
    .hit_count    (hit_count),
    .miss_count   (miss_count)
  );

  // Upstream contract: request payload is stable while stalled.
  a_req_stable: assert property (@(posedge clk) disable iff (rst)
    ((mem_read || mem_write) && !ready) |=> ($stable(address) && $stable(write_data)))
    else $error("request changed while stalled");

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issues one request starting at a negedge and runs it to completion.
  // dm_ready stays low for the first dm_wait cycles in which a dm strobe is seen.
  // Returns with the request dropped just after the completing posedge.
  task automatic xfer(input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] dmd, input int dm_wait,
                      output logic [31:0] rdata, output int cycles,
                      output int n_dmrd, output int n_dmwr);
    int strobes;
    strobes = 0;
    cycles  = 0;
    n_dmrd  = 0;
    n_dmwr  = 0;
    rdata   = 'x;
    @(negedge clk);
    mem_read     = rd;
    mem_write    = wr;
    address      = a;
    write_data   = wd;
    dm_read_data = dmd;
    forever begin
      dm_ready = (strobes >= dm_wait);
      #1;
      cycles++;
      if (dm_read)  n_dmrd++;
      if (dm_write) n_dmwr++;
      if (dm_read || dm_write) strobes++;
      if (ready) begin
        rdata = read_data;
        break;
      end
      if (cycles > 50) begin
        chk("timeout", 32'(cycles), 32'd0);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  logic [31:0] rd_v;
  int cyc, nr, nw;

  initial begin
    rst          = 1'b1;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    address      = '0;
    write_data   = '0;
    dm_read_data = '0;
    dm_ready     = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready",     32'(ready),      32'd1);
    chk("rst_dm_read",   32'(dm_read),    32'd0);
    chk("rst_dm_write",  32'(dm_write),   32'd0);
    chk("rst_read_data", read_data,       32'd0);
    chk("rst_hits",      32'(hit_count),  32'd0);
    chk("rst_misses",    32'(miss_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // cold read miss
    xfer(1, 0, 32'd1024, 0, 32'h1000_0000, 0, rd_v, cyc, nr, nw);
    chk("miss1_cycles", 32'(cyc), 32'd2);
    chk("miss1_data",   rd_v,     32'h1000_0000);
    chk("miss1_dmrd",   32'(nr),  32'd1);
    chk("miss1_cnt",    32'(miss_count), 32'd1);
    chk("miss1_hits",   32'(hit_count),  32'd0);

    // read hit, downstream data is different and must be ignored
    xfer(1, 0, 32'd1024, 0, 32'hFFFF_FFFF, 0, rd_v, cyc, nr, nw);
    chk("hit1_cycles", 32'(cyc), 32'd1);
    chk("hit1_data",   rd_v,     32'h1000_0000);
    chk("hit1_dmrd",   32'(nr),  32'd0);
    chk("hit1_cnt",    32'(hit_count), 32'd1);

    // write hit updates the line
    xfer(0, 1, 32'd1024, 32'hDEAD_BEEF, 0, 0, rd_v, cyc, nr, nw);
    chk("wr1_cycles", 32'(cyc), 32'd2);
    chk("wr1_dmwr",   32'(nw),  32'd1);
    xfer(1, 0, 32'd1024, 0, 32'h0BAD_0BAD, 0, rd_v, cyc, nr, nw);
    chk("hit2_cycles", 32'(cyc), 32'd1);
    chk("hit2_data",   rd_v,     32'hDEAD_BEEF);
    chk("hit2_dmrd",   32'(nr),  32'd0);
    chk("hit2_cnt",    32'(hit_count), 32'd2);

    // write miss does not allocate
    xfer(0, 1, 32'd1028, 32'h1234_5678, 0, 0, rd_v, cyc, nr, nw);
    chk("wr2_cycles", 32'(cyc), 32'd2);
    xfer(1, 0, 32'd1028, 0, 32'h1234_5678, 0, rd_v, cyc, nr, nw);
    chk("miss2_cycles", 32'(cyc), 32'd2);
    chk("miss2_data",   rd_v,     32'h1234_5678);
    chk("miss2_cnt",    32'(miss_count), 32'd2);

    // conflict on index 0: 1088 evicts 1024
    xfer(1, 0, 32'd1088, 0, 32'h2222_0000, 0, rd_v, cyc, nr, nw);
    chk("conf1_cycles", 32'(cyc), 32'd2);
    chk("conf1_data",   rd_v,     32'h2222_0000);
    xfer(1, 0, 32'd1024, 0, 32'hDEAD_BEEF, 3, rd_v, cyc, nr, nw);
    chk("conf2_cycles", 32'(cyc), 32'd5);
    chk("conf2_data",   rd_v,     32'hDEAD_BEEF);
    chk("conf2_dmrd",   32'(nr),  32'd4);
    xfer(1, 0, 32'd1088, 0, 32'h2222_0001, 0, rd_v, cyc, nr, nw);
    chk("conf3_data", rd_v, 32'h2222_0001);
    chk("conf3_cnt",  32'(miss_count), 32'd5);
    chk("conf3_hits", 32'(hit_count),  32'd2);

    // uncached: no fill, no counters
    xfer(1, 0, 32'h100, 0, 32'h0000_0055, 0, rd_v, cyc, nr, nw);
    chk("unc1_data", rd_v, 32'h0000_0055);
    xfer(1, 0, 32'h100, 0, 32'h0000_0066, 0, rd_v, cyc, nr, nw);
    chk("unc2_cycles", 32'(cyc), 32'd2);
    chk("unc2_data",   rd_v,     32'h0000_0066);
    chk("unc2_miss",   32'(miss_count), 32'd5);
    chk("unc2_hits",   32'(hit_count),  32'd2);

    // read+write together is a write; 1088 is valid so the line is updated
    xfer(1, 1, 32'd1088, 32'hCAFE_F00D, 0, 0, rd_v, cyc, nr, nw);
    chk("rw_cycles", 32'(cyc), 32'd2);
    chk("rw_dmwr",   32'(nw),  32'd1);
    chk("rw_dmrd",   32'(nr),  32'd0);
    xfer(1, 0, 32'd1088, 0, 32'h0, 0, rd_v, cyc, nr, nw);
    chk("rw_hit_data", rd_v, 32'hCAFE_F00D);
    chk("rw_hit_cyc",  32'(cyc), 32'd1);

    // reset during RD_MISS
    @(negedge clk);
    mem_read = 1'b1;
    address  = 32'd1032;
    dm_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("rm_dmrd_before", 32'(dm_read), 32'd1);
    rst = 1'b1;
    #1;
    chk("rm_dmrd_after", 32'(dm_read),    32'd0);
    chk("rm_hits",       32'(hit_count),  32'd0);
    chk("rm_misses",     32'(miss_count), 32'd0);
    mem_read = 1'b0;
    #1;
    chk("rm_idle_ready", 32'(ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    xfer(1, 0, 32'd1024, 0, 32'h3333_3333, 0, rd_v, cyc, nr, nw);
    chk("rm_next_cycles", 32'(cyc), 32'd2);
    chk("rm_next_miss",   32'(miss_count), 32'd1);

    // hit counter saturates at 15 with CNT_W=4
    for (int i = 0; i < 20; i++) begin
      xfer(1, 0, 32'd1024, 0, 32'h0, 0, rd_v, cyc, nr, nw);
    end
    chk("sat_data", rd_v, 32'h3333_3333);
    chk("sat_hits", 32'(hit_count), 32'd15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
